// File: rtl/seq_unit_arbiter_if.sv
// Handshake bundle between the requesters and the sequential-unit arbiter.
// The arbiter takes the slave side; the requester side (or a bench) takes master.
interface seq_unit_arbiter_if #(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] hold;
   logic [N_REQ-1:0] gnt;
   logic             allow;
   logic             x;
   logic             busy;
   logic             done;

   modport master (
      output req, hold,
      input  gnt, allow, x, busy, done
   );

   modport slave (
      input  req, hold,
      output gnt, allow, x, busy, done
   );
endinterface

// File: rtl/seq_unit_arbiter.sv
// Round-robin arbiter and sequencer for the x/allow unit: walks the granted
// requester through arm, trigger pulse, run, optional hold and release.
module seq_unit_arbiter #(
   parameter int N_REQ   = 2,
   parameter int ARM_CYC = 2,
   parameter int RUN_LEN = 4
) (
   input logic                clk,
   input logic                rst,
   seq_unit_arbiter_if.slave  bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int MAX_C = (ARM_CYC > RUN_LEN) ? ARM_CYC : RUN_LEN;
   localparam int CNT_W = $clog2(MAX_C) + 1;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      TRIG,
      RUN,
      HOLD,
      REL
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] win_nxt;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] rr_nxt;
   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         win_idx <= '0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         win_idx <= win_nxt;
         rr_ptr  <= rr_nxt;
      end
   end

   // First requester found scanning circularly from the round-robin pointer.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // The counter defaults to zero so every state change clears it.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      win_nxt   = win_idx;
      rr_nxt    = rr_ptr;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = ARM;
               win_nxt   = pick;
               rr_nxt    = (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
            end
         end
         ARM: begin
            if (cnt == CNT_W'(ARM_CYC - 1)) state_nxt = TRIG;
            else                            cnt_nxt   = cnt + 1'b1;
         end
         TRIG: state_nxt = RUN;
         RUN: begin
            if (cnt == CNT_W'(RUN_LEN - 1)) state_nxt = bus.hold[win_idx] ? HOLD : REL;
            else                            cnt_nxt   = cnt + 1'b1;
         end
         HOLD: begin
            if (!bus.req[win_idx]) state_nxt = REL;
         end
         REL:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs depend only on registered state, so x is never undefined.
   always_comb begin
      bus.gnt   = '0;
      bus.allow = 1'b0;
      bus.x     = 1'b0;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      if (state != IDLE) begin
         bus.gnt   = N_REQ'(1) << win_idx;
         bus.allow = 1'b1;
         bus.busy  = 1'b1;
         bus.x     = (state == TRIG) || (state == HOLD);
         bus.done  = (state == REL);
      end
   end

endmodule

// File: tb/tb_seq_unit_arbiter.sv
// Directed bench for seq_unit_arbiter at default parameters (2 requesters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_unit_arbiter;

   localparam int N_REQ   = 2;
   localparam int ARM_CYC = 2;
   localparam int RUN_LEN = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   check_count = 0;
   int   pass_count  = 0;
   int   fail_count  = 0;

   always #5 clk = ~clk;

   seq_unit_arbiter_if #(.N_REQ(N_REQ)) bus ();

   seq_unit_arbiter #(
      .N_REQ   (N_REQ),
      .ARM_CYC (ARM_CYC),
      .RUN_LEN (RUN_LEN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [1:0] r, input logic [1:0] h);
      bus.req  = r;
      bus.hold = h;
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] g, input logic a,
                              input logic xv, input logic b, input logic d);
      logic [5:0] obs;
      logic [5:0] exp;
      obs = {bus.gnt, bus.allow, bus.x, bus.busy, bus.done};
      exp = {g, a, xv, b, d};
      check_count++;
      assert (obs === exp) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s: gnt,allow,x,busy,done observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic resetDut(input int n);
      rst = 1'b1;
      applyStimulus(2'b00, 2'b00);
      repeat (n) tick();
      checkOutput("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   // Expected outputs of transaction cycle c: ARM 1..ARM_CYC, TRIG, RUN_LEN RUN
   // cycles, hold_cyc HOLD cycles, then REL; optionally rewrites req mid-way.
   task automatic runTx(input string tag, input logic [1:0] g, input int hold_cyc,
                        input int mid_cycle, input logic [1:0] mid_req, input int last_cycle);
      int   total;
      int   stop;
      logic trig;
      logic in_hold;
      logic rel;
      total = ARM_CYC + RUN_LEN + hold_cyc + 2;
      stop  = (last_cycle > 0) ? last_cycle : total;
      for (int c = 1; c <= stop; c++) begin
         tick();
         trig    = (c == ARM_CYC + 1);
         in_hold = (c > ARM_CYC + 1 + RUN_LEN) && (c < total);
         rel     = (c == total);
         checkOutput($sformatf("%s_c%0d", tag, c), g, 1'b1, trig | in_hold, 1'b1, rel);
         if (c == mid_cycle) bus.req = mid_req;
      end
   endtask

   initial begin
      $display("[TB] seq_unit_arbiter directed run");

      // Single requester, no hold
      resetDut(3);
      checkOutput("idle_after_reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b01, 2'b00);
      runTx("t1", 2'b01, 0, 8, 2'b00, 0);
      tick();
      checkOutput("t1_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Hold for five cycles, released by dropping req
      applyStimulus(2'b01, 2'b01);
      runTx("t2", 2'b01, 5, 12, 2'b00, 0);
      tick();
      checkOutput("t2_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Both requesting continuously: alternating grants with an idle gap
      resetDut(1);
      applyStimulus(2'b11, 2'b00);
      runTx("t3a", 2'b01, 0, 0, 2'b00, 0);
      tick();
      checkOutput("t3_gap1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      runTx("t3b", 2'b10, 0, 0, 2'b00, 0);
      tick();
      checkOutput("t3_gap2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      runTx("t3c", 2'b01, 0, 8, 2'b00, 0);
      tick();
      checkOutput("t3_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Requester 1 arrives mid-transaction and is served after one idle cycle
      resetDut(1);
      applyStimulus(2'b01, 2'b00);
      runTx("t4a", 2'b01, 0, 4, 2'b11, 0);
      tick();
      checkOutput("t4_gap", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      runTx("t4b", 2'b10, 0, 8, 2'b00, 0);
      tick();
      checkOutput("t4_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset during RUN and during HOLD; round-robin pointer returns to 0
      resetDut(1);
      applyStimulus(2'b11, 2'b01);
      runTx("t5a", 2'b01, 0, 0, 2'b00, 5);
      rst = 1'b1;
      tick();
      checkOutput("t5_rst_run", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      runTx("t5b", 2'b01, 3, 0, 2'b00, 9);
      rst = 1'b1;
      tick();
      checkOutput("t5_rst_hold", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(2'b11, 2'b00);
      runTx("t5c", 2'b01, 0, 0, 2'b00, 1);

      // Request dropped during ARM: sequence still completes, one done pulse
      resetDut(1);
      applyStimulus(2'b01, 2'b00);
      runTx("t6", 2'b01, 0, 1, 2'b00, 0);
      tick();
      checkOutput("t6_idle1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("t6_idle2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
